// File: rtl/sram_rr_ctrl.sv
// Round-robin arbiter of N_CH channels onto one asynchronous SRAM port.
// One access per grant: IDLE (grant) -> ACCESS (WAIT_CYC+1 cycles) -> DONE (completion strobe).
module sram_rr_ctrl #(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 32,
  parameter int PADDR_W  = 20,
  parameter int WAIT_CYC = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [N_CH-1:0]                     i_req,
  input  logic [N_CH-1:0]                     i_we,
  input  logic [N_CH-1:0][DATA_W/8-1:0]       i_be,
  input  logic [N_CH-1:0][31:0]               i_vaddr,
  input  logic [N_CH-1:0][DATA_W-1:0]         i_wdata,
  output logic [N_CH-1:0]                     o_gnt,
  output logic [N_CH-1:0]                     o_rvalid,
  output logic [DATA_W-1:0]                   o_rdata,
  output logic                                o_busy,
  output logic                                o_sram_ce_n,
  output logic                                o_sram_oe_n,
  output logic                                o_sram_we_n,
  output logic [DATA_W/8-1:0]                 o_sram_be_n,
  output logic [PADDR_W-1:0]                  o_sram_paddr,
  output logic [DATA_W-1:0]                   o_sram_wdata,
  input  logic [DATA_W-1:0]                   i_sram_rdata
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]          r_state;
  logic [2:0]          r_cnt;
  logic [IDX_W-1:0]    r_last, r_ch;
  logic                r_we;
  logic                r_ce_n, r_oe_n, r_we_n;
  logic [DATA_W/8-1:0] r_be_n;
  logic [PADDR_W-1:0]  r_paddr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [N_CH-1:0]     r_rvalid;

  logic [IDX_W-1:0]    w_hi, w_lo, w_win;
  logic                w_hi_v, w_lo_v, w_any, w_idle;
  logic                w_unused;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest at/below it.
  always_comb begin
    w_hi   = '0;
    w_lo   = '0;
    w_hi_v = 1'b0;
    w_lo_v = 1'b0;
    for (int j = N_CH-1; j >= 0; j--) begin
      if (i_req[j]) begin
        if (j > int'(r_last)) begin
          w_hi   = IDX_W'(j);
          w_hi_v = 1'b1;
        end else begin
          w_lo   = IDX_W'(j);
          w_lo_v = 1'b1;
        end
      end
    end
  end

  assign w_win  = w_hi_v ? w_hi : w_lo;
  assign w_any  = w_hi_v | w_lo_v;
  assign w_idle = (r_state == S_IDLE);

  assign o_gnt  = (w_idle && w_any && !i_rst) ? (N_CH'(1) << w_win) : '0;
  assign o_busy = !w_idle;

  // Byte-offset and high address bits carry no meaning for the word-addressed SRAM.
  always_comb begin
    w_unused = 1'b0;
    for (int c = 0; c < N_CH; c++)
      w_unused = w_unused ^ (^i_vaddr[c][1:0]) ^ (^i_vaddr[c][31:PADDR_W+2]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_last   <= IDX_W'(N_CH-1);
      r_ch     <= '0;
      r_we     <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_be_n   <= '1;
      r_paddr  <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_ACCESS;
            r_cnt   <= 3'(WAIT_CYC);
            r_last  <= w_win;
            r_ch    <= w_win;
            r_we    <= i_we[w_win];
            r_ce_n  <= 1'b0;
            r_oe_n  <= i_we[w_win];
            r_we_n  <= ~i_we[w_win];
            r_be_n  <= ~i_be[w_win];
            r_paddr <= i_vaddr[w_win][PADDR_W+1:2];
            if (i_we[w_win]) r_wdata <= i_wdata[w_win];
          end
        end
        S_ACCESS: begin
          if (r_cnt == 3'd0) begin
            r_state  <= S_DONE;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_be_n   <= '1;
            r_rvalid <= N_CH'(1) << r_ch;
            if (!r_we) r_rdata <= i_sram_rdata;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        // Address and write data stay put here to give the write hold time.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rvalid     = r_rvalid;
  assign o_rdata      = r_rdata;
  assign o_sram_ce_n  = r_ce_n;
  assign o_sram_oe_n  = r_oe_n;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_be_n  = r_be_n;
  assign o_sram_paddr = r_paddr;
  assign o_sram_wdata = r_wdata;

endmodule

// File: doc/sram_rr_ctrl.md
Name: sram_rr_ctrl

Overview:
- Parametrised successor to the fixed two-port instruction/data SRAM controller.
- Arbitrates N_CH requesting channels onto one external asynchronous SRAM port.
- Uses round-robin fairness, a programmable number of wait cycles, and per-channel completion strobes.
- Sits between the CPU/DMA masters and the board SRAM pins.

Parameters:
- N_CH, 2, number of requesting channels (1..8)
- DATA_W, 32, data width; byte enables = DATA_W/8
- PADDR_W, 20, physical word-address width
- WAIT_CYC, 1, extra strobe cycles per access (0..7)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- REQ  in  N_CH  per-channel request; held with payload until GNT
- WE  in  N_CH  per-channel write (1) / read (0)
- BE  in  N_CH*DATA_W/8  per-channel byte enables, active-high
- VADDR  in  N_CH*32  per-channel byte address
- WDATA  in  N_CH*DATA_W  per-channel write data
- GNT  out  N_CH  one-hot accept strobe, combinational, IDLE state only
- RVALID  out  N_CH  one-hot one-cycle completion strobe (reads and writes)
- RDATA  out  DATA_W  read data of last completed read
- BUSY  out  1  high in any state other than IDLE
- SRAM_CE_N  out  1  chip enable, active-low
- SRAM_OE_N  out  1  output enable, active-low
- SRAM_WE_N  out  1  write enable, active-low
- SRAM_BE_N  out  DATA_W/8  byte enables, active-low
- SRAM_PADDR  out  PADDR_W  word address = VADDR[PADDR_W+1:2]
- SRAM_WDATA  out  DATA_W  write data driven to pins
- SRAM_RDATA  in  DATA_W  data from pins

Behaviour:

Reset values:
- SRAM_CE_N/OE_N/WE_N = 1; SRAM_BE_N = all 1.
- SRAM_PADDR = 0, SRAM_WDATA = 0, RDATA = 0.
- GNT = 0, RVALID = 0, BUSY = 0.
- State = IDLE; round-robin pointer last = N_CH-1, so channel 0 wins first.

FSM: IDLE -> ACCESS -> DONE -> IDLE.

IDLE:
- If any REQ is set, choose the winner k = first set REQ searching last+1, last+2, ... modulo N_CH.
- GNT[k] = 1 this cycle.
- Latch WE[k], BE[k], VADDR[k] (as PADDR) and WDATA[k].
- last <= k; go to ACCESS; wait counter <= WAIT_CYC.
- No REQ: stay in IDLE, pins inactive.

ACCESS (lasts WAIT_CYC+1 cycles):
- SRAM_CE_N = 0; SRAM_BE_N = ~latched BE.
- Read: OE_N = 0, WE_N = 1.
- Write: WE_N = 0, OE_N = 1; SRAM_WDATA = latched data.
- The counter decrements each cycle; at 0 go to DONE.
- On a read, SRAM_RDATA is sampled into RDATA on the last ACCESS cycle.

DONE (1 cycle):
- CE_N, OE_N and WE_N all return to 1.
- PADDR and WDATA are held so the write has hold time.
- RVALID[k] = 1; next state IDLE.
- No grant is issued in DONE.

Throughput and latency:
- One access every WAIT_CYC+3 cycles.
- GNT to RVALID latency = WAIT_CYC+2 cycles.

Invariants and boundary conditions:
- Pins are all registered outputs.
- RDATA holds its value until the next read completes; writes never modify it.
- REQ deasserted before GNT: request dropped, no side effect.
- REQ held after GNT: treated as a new request in the next IDLE cycle.
- N_CH = 1: pointer logic degenerates; channel 0 is always granted.
- Asynchronous reset mid-access:
  - all strobes deassert immediately;
  - the access is aborted and no RVALID is issued;
  - the pointer resets.
- VADDR bits [1:0] are ignored; bits above PADDR_W+1 are ignored (no error).
- GNT and RVALID are never set for more than one channel at a time.

Test Plan:
1. Reset mid-write (RST high during ACCESS, WAIT_CYC=3) -> SRAM_WE_N=1 and SRAM_CE_N=1 asynchronously; no RVALID; after release, a new REQ[1] is granted before REQ[0] only if REQ[0]=0.
2. Single read, ch0, VADDR=0x0000_0010, WAIT_CYC=1, SRAM_RDATA=0xDEADBEEF:
   - GNT[0] at cycle 0;
   - CE_N/OE_N low for cycles 1-2, PADDR=0x00004;
   - RVALID[0] at cycle 3 with RDATA=0xDEADBEEF.
3. Write, ch1, BE=4'b0011, WDATA=0x12345678, WAIT_CYC=0:
   - WE_N low for exactly 1 cycle;
   - SRAM_BE_N=4'b1100;
   - WDATA stable through DONE;
   - RVALID[1]=1 one cycle later; RDATA unchanged.
4. Round-robin, N_CH=3, all REQ held high for 6 accesses -> grant order 0,1,2,0,1,2; BUSY low for exactly 1 cycle between accesses.
5. Request withdrawal: REQ[2] pulses for 1 cycle while BUSY=1 -> never granted, no RVALID[2]; REQ[0] asserted in the same cycle and held -> granted at the next IDLE cycle.
6. WAIT_CYC=7, back-to-back reads from ch0 -> each access has 8 ACCESS cycles; RVALID is spaced 10 cycles apart.
